mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-port arbiter that shares one 64-bit memory port between the RV64 core's instruction-fetch path (port 0, read-only) and its load/store path (port 1, read/write). It sits between the core datapath and the memory model / bus bridge. It accepts one transaction at a time with round-robin fairness, routes the response back to its owner, and returns an error response if memory does not respond within a programmable timeout.

## Interface
Parameters:
- XLEN, 64, address width of both requester ports and the memory port.
- TIMEOUT, 1023, cycles allowed in WAIT before an error response; 0 disables the timeout.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTn  input  1  reset, asynchronous, active-low.
- IF_REQ_VALID  input  1  fetch request.
- IF_REQ_READY  output  1  fetch request accepted this cycle.
- IF_ADDR  input  XLEN  fetch byte address, 4-byte aligned.
- IF_RESP_VALID  output  1  fetch response strobe, one cycle.
- IF_RDATA  output  32  instruction word.
- IF_RESP_ERR  output  1  fetch timed out; qualified by IF_RESP_VALID.
- LS_REQ_VALID  input  1  load/store request.
- LS_REQ_READY  output  1  load/store request accepted this cycle.
- LS_ADDR  input  XLEN  byte address.
- LS_WE  input  1  1 = store, 0 = load.
- LS_WSTRB  input  8  store byte enables.
- LS_WDATA  input  64  store data.
- LS_RESP_VALID  output  1  response strobe; also asserted for stores as the write acknowledge.
- LS_RDATA  output  64  load data.
- LS_RESP_ERR  output  1  timed out.
- M_REQ_VALID  output  1  memory request.
- M_REQ_READY  input  1  memory accepts the request.
- M_ADDR  output  XLEN  address, registered.
- M_WE  output  1  write enable, registered.
- M_WSTRB  output  8  byte enables, registered.
- M_WDATA  output  64  write data, registered.
- M_RESP_VALID  input  1  memory response; exactly one per accepted request.
- M_RDATA  input  64  read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset value is IDLE.
- Reset values: all outputs 0, all registers 0, last_grant = 1 (so port 0 wins the first tie), timeout counter = 0, owner = 0.
- **IDLE**
  - Grant is combinational. With one valid port, that port wins. With both valid, the port != last_grant wins.
  - The winner's REQ_READY = 1. The loser's REQ_READY = 0.
  - On the accept edge, latch addr/we/wstrb/wdata into the M_* registers, set owner and last_grant to the winner, and go to ISSUE.
  - A fetch latches we = 0 and wstrb = 0.
  - A read latches wstrb = 0 and wdata = 0.
- **ISSUE**
  - M_REQ_VALID = 1 with stable M_* fields.
  - On M_REQ_READY: clear the counter and go to WAIT.
  - ISSUE has no timeout.
- **WAIT**
  - The counter increments each cycle.
  - On M_RESP_VALID: drive owner's RESP_VALID = 1 combinationally in the same cycle with ERR = 0, then go to IDLE.
  - Owner 0 takes IF_RDATA = M_ADDR[2] ? M_RDATA[63:32] : M_RDATA[31:0].
  - Owner 1 takes LS_RDATA = M_RDATA.
  - If TIMEOUT != 0, M_RESP_VALID = 0 and counter == TIMEOUT-1: drive owner's RESP_VALID = 1 with RESP_ERR = 1 and RDATA = 0, then go to IDLE.
  - If M_RESP_VALID and the timeout coincide, the real response wins and ERR = 0.
- A late M_RESP_VALID arriving in IDLE or ISSUE is ignored. No requester output changes.
- The non-owner's RESP_VALID is always 0. RDATA outputs are 0 whenever their RESP_VALID = 0.
- REQ_READY is 0 in ISSUE and WAIT. Requesters hold VALID and fields until READY.
- Asserting RSTn low mid-transaction returns the FSM to IDLE immediately and drops the transaction. No response is issued.

## Timing
- Accept at edge T. M_REQ_VALID is high in cycle T+1.
- With M_REQ_READY at T+1 and M_RESP_VALID at T+2, the requester sees RESP_VALID in cycle T+2.
- The next accept can occur at edge T+3. Best-case throughput is one transaction per 3 cycles.
- Zero-cycle combinational paths, same cycle:
  - M_RESP_VALID / M_RDATA to Px_RESP_VALID / RDATA.
  - Px_REQ_VALID to Px_REQ_READY.
- M_* outputs are registered.
- Timeout: with TIMEOUT = N, the error response appears in the N-th cycle spent in WAIT.

## Test plan
- Single fetch: IF_ADDR = 0x8000_0004, memory ready immediately and responds next cycle with M_RDATA = 0x1111_2222_3333_4444 -> IF_RESP_VALID for one cycle with IF_RDATA = 0x1111_2222, ERR = 0, and LS_RESP_VALID stays 0.
- Store: LS_WE = 1, LS_WSTRB = 0x0F, LS_WDATA = 0xDEAD_BEEF, LS_ADDR = 0x8000_1000 -> M_WE = 1, M_WSTRB = 0x0F, M_WDATA = 0xDEAD_BEEF in ISSUE, and LS_RESP_VALID with the ack.
- Contention: both ports hold VALID continuously for 6 transactions after reset -> grant order 0,1,0,1,0,1 and each RESP goes only to its owner.
- Backpressure and latency: M_REQ_READY low for 4 cycles, then response after 5 more cycles -> M_* fields stable throughout, no REQ_READY during the transaction, exactly one RESP_VALID.
- Timeout: TIMEOUT = 8, memory accepts but never responds -> LS_RESP_VALID with ERR = 1 and RDATA = 0 in the 8th WAIT cycle, back to IDLE, and a later stray M_RESP_VALID is ignored.
- Reset mid-WAIT: drop RSTn for 1 cycle -> all outputs 0, FSM in IDLE, and the next tie grants port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch path (port 0, read-only)
// and the load/store path (port 1, read/write). One transaction is in flight at
// a time. Ties are broken round-robin. Responses are routed back to the port
// that issued the request. If memory does not respond within TIMEOUT cycles of
// accepting a request, an error response is returned instead.
//
// Ports:
//   CLK, RSTn             clock (posedge), asynchronous active-low reset
//   IF_REQ_* / IF_ADDR    fetch request handshake and address
//   IF_RESP_* / IF_RDATA  fetch response strobe, 32-bit instruction word, error
//   LS_REQ_* / LS_*       load/store request handshake, address, we, wstrb, wdata
//   LS_RESP_* / LS_RDATA  load/store response strobe (also the store ack), data, error
//   M_REQ_* / M_*         memory request handshake and registered request fields
//   M_RESP_VALID, M_RDATA memory response, exactly one per accepted request
module mem_port_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IF_REQ_VALID,
  output logic            IF_REQ_READY,
  input  logic [XLEN-1:0] IF_ADDR,
  output logic            IF_RESP_VALID,
  output logic [31:0]     IF_RDATA,
  output logic            IF_RESP_ERR,
  input  logic            LS_REQ_VALID,
  output logic            LS_REQ_READY,
  input  logic [XLEN-1:0] LS_ADDR,
  input  logic            LS_WE,
  input  logic [7:0]      LS_WSTRB,
  input  logic [63:0]     LS_WDATA,
  output logic            LS_RESP_VALID,
  output logic [63:0]     LS_RDATA,
  output logic            LS_RESP_ERR,
  output logic            M_REQ_VALID,
  input  logic            M_REQ_READY,
  output logic [XLEN-1:0] M_ADDR,
  output logic            M_WE,
  output logic [7:0]      M_WSTRB,
  output logic [63:0]     M_WDATA,
  input  logic            M_RESP_VALID,
  input  logic [63:0]     M_RDATA
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT=0 still elaborates.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          TO_EN   = (TIMEOUT != 0);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic            m_we_q, m_we_d;
  logic [7:0]      m_wstrb_q, m_wstrb_d;
  logic [63:0]     m_wdata_q, m_wdata_d;

  logic            req_any_s;
  logic            winner_s;
  logic            timeout_s;
  logic            resp_s;
  logic            err_s;

  // Round-robin grant: a lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    req_any_s = IF_REQ_VALID | LS_REQ_VALID;
    if (IF_REQ_VALID && LS_REQ_VALID) begin
      winner_s = ~last_grant_q;
    end else if (LS_REQ_VALID) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Response/timeout qualification in WAIT; a real response beats a coincident timeout.
  always_comb begin
    timeout_s = TO_EN && (state_q == ST_WAIT) && !M_RESP_VALID && (cnt_q == TO_LAST);
    resp_s    = (state_q == ST_WAIT) && (M_RESP_VALID || timeout_s);
    err_s     = timeout_s;
  end

  // State register and request/bookkeeping registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= {CW{1'b0}};
      m_addr_q     <= {XLEN{1'b0}};
      m_we_q       <= 1'b0;
      m_wstrb_q    <= 8'h00;
      m_wdata_q    <= 64'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_addr_q     <= m_addr_d;
      m_we_q       <= m_we_d;
      m_wstrb_q    <= m_wstrb_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  // Next-state logic: accept in IDLE, hand off in ISSUE, count and finish in WAIT.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_addr_d     = m_addr_q;
    m_we_d       = m_we_q;
    m_wstrb_d    = m_wstrb_q;
    m_wdata_d    = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          state_d      = ST_ISSUE;
          owner_d      = winner_s;
          last_grant_d = winner_s;
          if (winner_s == 1'b0) begin
            m_addr_d  = IF_ADDR;
            m_we_d    = 1'b0;
            m_wstrb_d = 8'h00;
            m_wdata_d = 64'h0;
          end else begin
            m_addr_d = LS_ADDR;
            m_we_d   = LS_WE;
            // Loads carry no byte enables or data so the memory side sees clean fields.
            if (LS_WE) begin
              m_wstrb_d = LS_WSTRB;
              m_wdata_d = LS_WDATA;
            end else begin
              m_wstrb_d = 8'h00;
              m_wdata_d = 64'h0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (M_REQ_READY) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1'b1);
        if (resp_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: handshakes and response routing to the owner only.
  always_comb begin
    IF_REQ_READY  = (state_q == ST_IDLE) && req_any_s && (winner_s == 1'b0);
    LS_REQ_READY  = (state_q == ST_IDLE) && req_any_s && (winner_s == 1'b1);
    M_REQ_VALID   = (state_q == ST_ISSUE);
    M_ADDR        = m_addr_q;
    M_WE          = m_we_q;
    M_WSTRB       = m_wstrb_q;
    M_WDATA       = m_wdata_q;
    IF_RESP_VALID = resp_s && (owner_q == 1'b0);
    IF_RESP_ERR   = err_s && (owner_q == 1'b0);
    LS_RESP_VALID = resp_s && (owner_q == 1'b1);
    LS_RESP_ERR   = err_s && (owner_q == 1'b1);
    // Data is only passed through for a real response; error responses return zero.
    if (IF_RESP_VALID && !err_s) begin
      IF_RDATA = m_addr_q[2] ? M_RDATA[63:32] : M_RDATA[31:0];
    end else begin
      IF_RDATA = 32'h0;
    end
    if (LS_RESP_VALID && !err_s) begin
      LS_RDATA = M_RDATA;
    end else begin
      LS_RDATA = 64'h0;
    end
  end

endmodule
